tcp_vlg_rx_seq_chk: RTL and testbench

Sequence checker between the TCP RX header/payload parser and the TCP RX control stage. It compares each received segment's sequence number against the expected local acknowledgement number. In-order bytes are forwarded downstream. Duplicate and out-of-order segments are dropped. The block maintains `loc_ack` and pulses an ACK request to the TCP transmit side after every checked segment.

---
 rtl/tcp_vlg_rx_seq_chk_if.sv | 24 ++
 rtl/tcp_vlg_rx_seq_chk.sv | 213 +++++++++++++++++++++
 tb/tb_tcp_vlg_rx_seq_chk.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tcp_vlg_rx_seq_chk_if.sv
// Segment header/payload bus from the RX parser and the forwarded byte stream.
interface tcp_vlg_rx_seq_chk_if;
  logic        in_val;
  logic [31:0] in_seq;
  logic [15:0] in_len;
  logic        in_fin;
  logic [7:0]  in_dat;
  logic        in_dat_val;
  logic        in_dat_eof;
  logic [7:0]  out_dat;
  logic        out_val;
  logic        out_eof;
  logic        out_err;

  modport master (
    output in_val, in_seq, in_len, in_fin, in_dat, in_dat_val, in_dat_eof,
    input  out_dat, out_val, out_eof, out_err
  );

  modport slave (
    input  in_val, in_seq, in_len, in_fin, in_dat, in_dat_val, in_dat_eof,
    output out_dat, out_val, out_eof, out_err
  );
endinterface

// File: rtl/tcp_vlg_rx_seq_chk.sv
// TCP RX sequence checker: forwards in-order payload, drops duplicate/out-of-order segments.
// Optional macro TCP_RX_TRIM_EN: trim partially overlapping segments instead of dropping them.
module tcp_vlg_rx_seq_chk #(
  parameter int unsigned WIN_MAX = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init,
  input  logic [31:0]                init_ack,
  input  logic                       close,
  tcp_vlg_rx_seq_chk_if.slave        bus,
  output logic [31:0]                loc_ack,
  output logic                       ack_req,
  output logic                       dup,
  output logic                       ooo,
  output logic                       inv
);

`ifdef TCP_RX_TRIM_EN
  typedef enum logic [1:0] {IDLE, PASS, DROP, SKIP} state_t;
`else
  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;
`endif

  localparam logic signed [31:0] WIN_S = 32'(WIN_MAX);

  state_t      state_q, state_d;
  logic [31:0] loc_ack_q, loc_ack_d;
  logic        active_q, active_d;
  logic        close_pend_q, close_pend_d;
  logic [15:0] fc_q, fc_d;
  logic [15:0] rc_q, rc_d;
  logic [15:0] len_q, len_d;
  logic        fin_q, fin_d;
`ifdef TCP_RX_TRIM_EN
  logic [15:0] skip_q, skip_d;
`endif
  logic [7:0]  out_dat_q, out_dat_d;
  logic        out_val_q, out_val_d;
  logic        out_eof_q, out_eof_d;
  logic        out_err_q, out_err_d;
  logic        ack_q, ack_d;
  logic        dup_q, dup_d;
  logic        ooo_q, ooo_d;
  logic        inv_q, inv_d;

  logic signed [31:0] d_s, e_s;
  logic               seg_end, to_idle;

  always_comb begin
    state_d      = state_q;
    loc_ack_d    = loc_ack_q;
    active_d     = active_q;
    close_pend_d = close_pend_q;
    fc_d         = fc_q;
    rc_d         = rc_q;
    len_d        = len_q;
    fin_d        = fin_q;
`ifdef TCP_RX_TRIM_EN
    skip_d       = skip_q;
`endif
    out_dat_d    = out_dat_q;
    out_val_d    = 1'b0;
    out_eof_d    = 1'b0;
    out_err_d    = 1'b0;
    ack_d        = 1'b0;
    dup_d        = 1'b0;
    ooo_d        = 1'b0;
    inv_d        = 1'b0;
    seg_end      = 1'b0;
    to_idle      = 1'b0;
    d_s          = $signed(bus.in_seq - loc_ack_q);
    e_s          = d_s + $signed({16'h0, bus.in_len});

    if (init) begin
      state_d      = IDLE;
      loc_ack_d    = init_ack;
      active_d     = 1'b1;
      close_pend_d = 1'b0;
    end else begin
      if (state_q != IDLE && close) close_pend_d = 1'b1;
      case (state_q)
        IDLE: begin
          if (close) begin
            active_d = 1'b0;
          end else if (active_q && bus.in_val && (bus.in_len != '0 || bus.in_fin)) begin
            fc_d  = '0;
            rc_d  = '0;
            len_d = bus.in_len;
            fin_d = bus.in_fin;
            if (d_s == 0) begin
              if (bus.in_len == '0) begin
                loc_ack_d = loc_ack_q + 32'd1;
                ack_d     = 1'b1;
              end else begin
                state_d = PASS;
              end
            end else begin
`ifdef TCP_RX_TRIM_EN
              if (d_s < 0 && e_s > 0) begin
                state_d = SKIP;
                skip_d  = 16'(-d_s);
              end else begin
`else
              begin
`endif
                // Zero-length drops (FIN only) carry no payload, so stay in IDLE.
                ack_d = 1'b1;
                if (d_s < 0)          dup_d = 1'b1;
                else if (d_s > WIN_S) inv_d = 1'b1;
                else                  ooo_d = 1'b1;
                if (bus.in_len != '0) state_d = DROP;
              end
            end
          end
        end
        PASS: begin
          if (bus.in_dat_val) begin
            out_val_d = 1'b1;
            out_dat_d = bus.in_dat;
            fc_d      = fc_q + 16'd1;
            rc_d      = rc_q + 16'd1;
            seg_end   = bus.in_dat_eof;
          end
        end
`ifdef TCP_RX_TRIM_EN
        SKIP: begin
          if (bus.in_dat_val) begin
            rc_d    = rc_q + 16'd1;
            skip_d  = skip_q - 16'd1;
            seg_end = bus.in_dat_eof;
            if (!bus.in_dat_eof && skip_q == 16'd1) state_d = PASS;
          end
        end
`endif
        DROP: begin
          if (bus.in_dat_val && bus.in_dat_eof) to_idle = 1'b1;
        end
        default: state_d = IDLE;
      endcase

      if (seg_end) begin
        to_idle   = 1'b1;
        out_eof_d = 1'b1;
        ack_d     = 1'b1;
        if (rc_d != len_q) out_err_d = 1'b1;
        else               loc_ack_d = loc_ack_q + 32'(fc_d) + 32'(fin_q);
      end
      if (to_idle) begin
        state_d = IDLE;
        if (close || close_pend_q) begin
          active_d     = 1'b0;
          close_pend_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      loc_ack_q    <= '0;
      active_q     <= 1'b0;
      close_pend_q <= 1'b0;
      fc_q         <= '0;
      rc_q         <= '0;
      len_q        <= '0;
      fin_q        <= 1'b0;
`ifdef TCP_RX_TRIM_EN
      skip_q       <= '0;
`endif
      out_dat_q    <= '0;
      out_val_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      out_err_q    <= 1'b0;
      ack_q        <= 1'b0;
      dup_q        <= 1'b0;
      ooo_q        <= 1'b0;
      inv_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      loc_ack_q    <= loc_ack_d;
      active_q     <= active_d;
      close_pend_q <= close_pend_d;
      fc_q         <= fc_d;
      rc_q         <= rc_d;
      len_q        <= len_d;
      fin_q        <= fin_d;
`ifdef TCP_RX_TRIM_EN
      skip_q       <= skip_d;
`endif
      out_dat_q    <= out_dat_d;
      out_val_q    <= out_val_d;
      out_eof_q    <= out_eof_d;
      out_err_q    <= out_err_d;
      ack_q        <= ack_d;
      dup_q        <= dup_d;
      ooo_q        <= ooo_d;
      inv_q        <= inv_d;
    end
  end

  assign bus.out_dat = out_dat_q;
  assign bus.out_val = out_val_q;
  assign bus.out_eof = out_eof_q;
  assign bus.out_err = out_err_q;
  assign loc_ack     = loc_ack_q;
  assign ack_req     = ack_q;
  assign dup         = dup_q;
  assign ooo         = ooo_q;
  assign inv         = inv_q;

endmodule

// File: tb/tb_tcp_vlg_rx_seq_chk.sv
// Randomised segment-level bench for tcp_vlg_rx_seq_chk with a per-cycle expectation table.
module tb_tcp_vlg_rx_seq_chk;
  localparam int WIN  = 65535;
  localparam int MAXC = 8192;

  logic        clk;
  logic        rst;
  logic        init;
  logic [31:0] init_ack;
  logic        close;
  logic [31:0] loc_ack;
  logic        ack_req, dup, ooo, inv;

  tcp_vlg_rx_seq_chk_if bus();

  tcp_vlg_rx_seq_chk #(.WIN_MAX(WIN)) dut (
    .clk(clk), .rst(rst), .init(init), .init_ack(init_ack), .close(close),
    .bus(bus), .loc_ack(loc_ack), .ack_req(ack_req), .dup(dup), .ooo(ooo), .inv(inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expectation table indexed by cycle number.
  bit          chk_en [MAXC];
  bit          ev_val [MAXC], ev_eof [MAXC], ev_err [MAXC];
  bit          ev_ack [MAXC], ev_dup [MAXC], ev_ooo [MAXC], ev_inv [MAXC];
  logic [7:0]  ev_dat [MAXC];
  logic [31:0] ev_loc [MAXC];
  bit          lit_en [MAXC];
  logic [31:0] lit_v  [MAXC];

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [31:0] mloc = '0;
  bit          mactive = 1'b0;
  bit          mpend = 1'b0;
  bit          e_val, e_eof, e_err, e_ack, e_dup, e_ooo, e_inv;
  logic [7:0]  e_dat;

  always @(negedge clk) begin
    if (cyc < MAXC && chk_en[cyc]) begin
      checks++;
      if (bus.out_val !== ev_val[cyc] || (ev_val[cyc] && bus.out_dat !== ev_dat[cyc]) ||
          bus.out_eof !== ev_eof[cyc] || bus.out_err !== ev_err[cyc] || ack_req !== ev_ack[cyc] ||
          dup !== ev_dup[cyc] || ooo !== ev_ooo[cyc] || inv !== ev_inv[cyc] || loc_ack !== ev_loc[cyc]) begin
        failures++;
        $display("FAIL cycle_%0d got val=%b dat=%h eof=%b err=%b ack=%b dup=%b ooo=%b inv=%b loc=%h exp val=%b dat=%h eof=%b err=%b ack=%b dup=%b ooo=%b inv=%b loc=%h",
                 cyc, bus.out_val, bus.out_dat, bus.out_eof, bus.out_err, ack_req, dup, ooo, inv, loc_ack,
                 ev_val[cyc], ev_dat[cyc], ev_eof[cyc], ev_err[cyc], ev_ack[cyc], ev_dup[cyc], ev_ooo[cyc],
                 ev_inv[cyc], ev_loc[cyc]);
      end
    end
    if (cyc < MAXC && lit_en[cyc]) begin
      checks++;
      if (loc_ack !== lit_v[cyc]) begin
        failures++;
        $display("FAIL pin_loc_ack cycle_%0d got=%h exp=%h", cyc, loc_ack, lit_v[cyc]);
      end
    end
  end

  task automatic tick();
    int n;
    n = cyc + 1;
    if (n < MAXC) begin
      chk_en[n] = 1'b1;
      ev_val[n] = e_val; ev_dat[n] = e_dat; ev_eof[n] = e_eof; ev_err[n] = e_err;
      ev_ack[n] = e_ack; ev_dup[n] = e_dup; ev_ooo[n] = e_ooo; ev_inv[n] = e_inv;
      ev_loc[n] = mloc;
    end
    @(posedge clk);
    #1;
    {e_val, e_eof, e_err, e_ack, e_dup, e_ooo, e_inv} = '0;
    bus.in_val = 1'b0; bus.in_dat_val = 1'b0; bus.in_dat_eof = 1'b0;
    init = 1'b0; close = 1'b0; rst = 1'b1;
  endtask

  // Literal expectation on loc_ack as currently visible.
  task automatic pin(input logic [31:0] v);
    if (cyc < MAXC) begin
      lit_en[cyc] = 1'b1;
      lit_v[cyc]  = v;
    end
  endtask

  task automatic do_init(input logic [31:0] a);
    init = 1'b1; init_ack = a;
    mloc = a; mactive = 1'b1; mpend = 1'b0;
    tick();
  endtask

  // abort_kind: 0 = init at byte abort_at, 1 = reset at that byte, 2 = close at that byte.
  task automatic seg(input logic [31:0] seq, input int len, input bit fin, input int nb,
                     input int gapmax, input int abort_at, input int abort_kind,
                     input logic [31:0] new_ack);
    int d, skip, fwd, mode, g;
    longint e;
    logic [31:0] diff;
    diff = seq - mloc;
    d    = $signed(diff);
    e    = longint'(d) + longint'(len);
    skip = 0; fwd = 0; mode = 0;
    bus.in_val = 1'b1; bus.in_seq = seq; bus.in_len = 16'(len); bus.in_fin = fin;
    if (mactive && (len != 0 || fin)) begin
      if (d == 0 && len == 0) begin
        mloc  = mloc + 32'd1;
        e_ack = 1'b1;
      end else if (d == 0) begin
        mode = 1;
      end else if (d < 0 && e > 0) begin
`ifdef TCP_RX_TRIM_EN
        mode = 1; skip = -d;
`else
        e_dup = 1'b1; e_ack = 1'b1; mode = 2;
`endif
      end else begin
        if (d < 0)        e_dup = 1'b1;
        else if (d <= WIN) e_ooo = 1'b1;
        else              e_inv = 1'b1;
        e_ack = 1'b1;
        mode  = (len != 0) ? 2 : 0;
      end
    end
    tick();
    for (int k = 0; k < nb; k++) begin
      g = $urandom_range(gapmax, 0);
      repeat (g) tick();
      bus.in_dat_val = 1'b1;
      bus.in_dat     = 8'($urandom);
      bus.in_dat_eof = (k == nb - 1);
      if (k == abort_at) begin
        if (abort_kind == 0) begin
          init = 1'b1; init_ack = new_ack; mloc = new_ack; mactive = 1'b1; mpend = 1'b0; mode = 0;
        end else if (abort_kind == 1) begin
          rst = 1'b0; mloc = '0; mactive = 1'b0; mpend = 1'b0; mode = 0;
        end else begin
          close = 1'b1;
          if (mode == 0) mactive = 1'b0;
          else           mpend = 1'b1;
        end
      end
      if (mode == 1) begin
        if (k >= skip) begin
          e_val = 1'b1; e_dat = bus.in_dat; fwd++;
        end
        if (k == nb - 1) begin
          e_eof = 1'b1; e_ack = 1'b1; e_err = (nb != len);
          if (nb == len) mloc = mloc + 32'(fwd) + 32'(fin);
        end
      end
      if (k == nb - 1 && mode != 0 && mpend) begin
        mactive = 1'b0; mpend = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int cls, len, nb;
    bit fin;
    logic [31:0] s;
    rst = 1'b0; init = 1'b0; init_ack = '0; close = 1'b0;
    bus.in_val = 1'b0; bus.in_seq = '0; bus.in_len = '0; bus.in_fin = 1'b0;
    bus.in_dat = '0; bus.in_dat_val = 1'b0; bus.in_dat_eof = 1'b0;
    {e_val, e_eof, e_err, e_ack, e_dup, e_ooo, e_inv} = '0;
    e_dat = '0;
    repeat (3) begin rst = 1'b0; tick(); end
    pin(32'h0);

    do_init(32'h1000);
    seg(32'h1000, 4, 1'b0, 4, 0, -1, 0, '0);
    pin(32'h1004);
    seg(32'h1010, 8, 1'b0, 8, 1, -1, 0, '0);
    pin(32'h1004);
    seg(32'h1000, 8, 1'b0, 8, 1, -1, 0, '0);
`ifdef TCP_RX_TRIM_EN
    pin(32'h1008);
`else
    pin(32'h1004);
`endif

    do_init(32'hFFFF_FFFE);
    seg(32'hFFFF_FFFE, 4, 1'b1, 4, 1, -1, 0, '0);
    pin(32'h3);
    seg(32'h3, 5, 1'b0, 3, 0, -1, 0, '0);
    pin(32'h3);
    seg(32'h3 + WIN, 2, 1'b0, 2, 0, -1, 0, '0);
    seg(32'h3 + WIN + 1, 2, 1'b0, 2, 0, -1, 0, '0);
    seg(32'h8, 0, 1'b1, 0, 0, -1, 0, '0);
    pin(32'h3);
    seg(32'h3, 0, 1'b1, 0, 0, -1, 0, '0);
    pin(32'h4);
    seg(32'h4, 0, 1'b0, 0, 0, -1, 0, '0);
    pin(32'h4);

    seg(32'h4, 5, 1'b0, 5, 0, 2, 0, 32'h2000);
    pin(32'h2000);
    seg(32'h2000, 3, 1'b0, 3, 1, 1, 2, '0);
    pin(32'h2003);
    seg(32'h2003, 2, 1'b0, 2, 0, -1, 0, '0);
    pin(32'h2003);
    do_init(32'h5000);
    seg(32'h5000, 4, 1'b0, 4, 0, 2, 1, '0);
    pin(32'h0);
    do_init($urandom);

    for (int i = 0; i < 200; i++) begin
      cls = $urandom_range(7, 0);
      len = $urandom_range(8, 1);
      fin = ($urandom_range(3, 0) == 0);
      nb  = len;
      case (cls)
        0: s = mloc;
        1: s = mloc - 32'(len) - 32'($urandom_range(5, 0));
        2: begin
          if (len < 2) len = 2;
          nb = len;
          s  = mloc - 32'($urandom_range(len - 1, 1));
        end
        3: s = mloc + 32'($urandom_range(WIN, 1));
        4: s = mloc + 32'(WIN) + 32'd1 + 32'($urandom_range(1000, 0));
        5: begin s = mloc + 32'($urandom_range(3, 0)); len = 0; nb = 0; fin = 1'b0; end
        6: begin s = mloc; len = 0; nb = 0; fin = 1'b1; end
        default: begin s = mloc; nb = $urandom_range(len + 2, 1); end
      endcase
      if (i % 60 == 59) do_init($urandom);
      seg(s, len, fin, nb, 2, -1, 0, '0);
      repeat ($urandom_range(2, 0)) tick();
    end

    repeat (2) tick();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
